// File: rtl/serial_pkg.sv
// serial_pkg: line levels, frame width and FSM states shared by the serial transmitter and receiver.
package serial_pkg;
    localparam int DATA_BITS_DEF = 8;
    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } state_t;
endpackage

// File: rtl/serial_shift_in.sv
// serial_shift_in: LSB-first deserializer with a bit counter that flags the last payload bit.
module serial_shift_in
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
    logic [CW-1:0] cnt;
    assign done = en && cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= '0;
        end else begin
            if (clr) cnt <= '0;
            else if (en) cnt <= cnt + CW'(1);
            // shifting right lands the first received bit at position 0
            if (en) dout <= {din, dout[DATA_BITS-1:1]};
        end
    end
endmodule

// File: rtl/serial_rx.sv
// serial_rx: one-bit-per-cycle serial receiver with a single-entry output buffer and error pulses.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun
);
    state_t state;
    logic [DATA_BITS-1:0] sr;
    logic done;
    serial_shift_in #(.DATA_BITS(DATA_BITS)) u_shift (
        .clk (clk),
        .rst (rst),
        .clr (state != DATA),
        .en  (state == DATA),
        .din (rxd),
        .dout(sr),
        .done(done)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ack) rx_valid <= 1'b0;
            case (state)
                IDLE:   if (rxd == START_LVL) state <= DATA;
                DATA:   if (done) state <= STOP;
                STOP: begin
                    state <= rxd == STOP_LVL ? IDLE : RESYNC;
                    if (rxd != STOP_LVL) frame_err <= 1'b1;
                    else if (!rx_valid || rx_ack) begin
                        rx_data  <= sr;
                        rx_valid <= 1'b1;
                    end else overrun <= 1'b1;
                end
                RESYNC: if (rxd == IDLE_LVL) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
